// File: rtl/unshifter_if.sv
// Handshake bundle between the scaling stage, the unshifter and the recovery consumer.
// The slave modport is the unshifter's view of it; the master modport is its environment.
interface unshifter_if #(
  parameter int size = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [size-1:0] data_in;
  logic [1:0]      coefficient;
  logic            out_valid;
  logic            out_ready;
  logic [size-1:0] data_out;
  logic            lost;
  logic            illegal;

  modport slave (
    input  in_valid, data_in, coefficient, out_ready,
    output in_ready, out_valid, data_out, lost, illegal
  );

  modport master (
    output in_valid, data_in, coefficient, out_ready,
    input  in_ready, out_valid, data_out, lost, illegal
  );
endinterface

// File: rtl/unshifter_seq.sv
// Sequential inverse of the coefficient scaling shifter: undoes x2, x4 or /2 one bit per clock.
// It flags any '1' shifted out and passes illegal coefficient codes through untouched.
module unshifter_seq #(
  parameter int size = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  unshifter_if.slave    bus,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [size-1:0] data_q, data_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            left_q, left_d;
  logic            lost_q, lost_d;
  logic            illegal_q, illegal_d;

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      data_q    <= {size{1'b0}};
      cnt_q     <= 2'd0;
      left_q    <= 1'b0;
      lost_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      left_q    <= left_d;
      lost_q    <= lost_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state and working-register update.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    left_d    = left_q;
    lost_d    = lost_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          data_d    = bus.data_in;
          lost_d    = 1'b0;
          illegal_d = 1'b0;
          // Each code is undone by the opposite shift of the same magnitude.
          case (bus.coefficient)
            2'b00: begin cnt_d = 2'd1; left_d = 1'b0; end
            2'b01: begin cnt_d = 2'd2; left_d = 1'b0; end
            2'b10: begin cnt_d = 2'd1; left_d = 1'b1; end
            default: begin cnt_d = 2'd0; left_d = 1'b0; illegal_d = 1'b1; end
          endcase
          state_d = (bus.coefficient == 2'b11) ? DONE : SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (left_q) begin
          data_d = {data_q[size-2:0], 1'b0};
          lost_d = lost_q | data_q[size-1];
        end else begin
          data_d = {1'b0, data_q[size-1:1]};
          lost_d = lost_q | data_q[0];
        end
        cnt_d   = cnt_q - 2'd1;
        state_d = (cnt_q == 2'd1) ? DONE : SHIFT;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode directly from registered state, so none of them has a combinational input path.
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    busy          = (state_q != IDLE);
    bus.data_out  = data_q;
    bus.lost      = lost_q;
    bus.illegal   = illegal_q;
  end

endmodule

// File: tb/tb_unshifter_seq.sv
// Scoreboard bench for unshifter_seq: the driver queues hand-computed results at each accept,
// and an independent monitor pops and compares them on every output handshake.
module tb_unshifter_seq;

  localparam int SZ = 5;

  logic clk;
  logic rst_n;
  logic busy;

  unshifter_if #(.size(SZ)) bus ();

  unshifter_seq #(.size(SZ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [SZ-1:0] data;
    logic          lost;
    logic          illegal;
    int            delta;
    int            acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: latency on the rising out_valid, payload on every handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.out_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          chk("latency", cyc - exp_q[0].acc_cyc, exp_q[0].delta);
        end
      end
      if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
        chk("data_out", bus.data_out, exp_q[0].data);
        chk("lost", bus.lost, exp_q[0].lost);
        chk("illegal", bus.illegal, exp_q[0].illegal);
        void'(exp_q.pop_front());
      end
      prev_valid = bus.out_valid;
    end
  end

  // Complete an accept at the coming edge and queue the expected result.
  task automatic accept_push(input logic [SZ-1:0] ed, input logic el, input logic ei, input int delta);
    exp_t e;
    @(posedge clk);
    #1;
    e.data = ed; e.lost = el; e.illegal = ei; e.delta = delta; e.acc_cyc = cyc;
    exp_q.push_back(e);
    bus.in_valid = 1'b0;
    bus.data_in  = 5'b11111;
    bus.coefficient = 2'b11;
  endtask

  task automatic present(input logic [SZ-1:0] d, input logic [1:0] c);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.data_in = d;
    bus.coefficient = c;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic send(input logic [SZ-1:0] d, input logic [1:0] c,
                      input logic [SZ-1:0] ed, input logic el, input logic ei, input int delta);
    present(d, c);
    accept_push(ed, el, ei, delta);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  logic [SZ-1:0] held_data;
  logic          held_lost;
  int            n;

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.data_in = 5'b00000;
    bus.coefficient = 2'b00;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_data_out", bus.data_out, 5'b00000);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);

    // Plan items 1-4 plus extra edge patterns.
    send(5'b10110, 2'b00, 5'b01011, 1'b0, 1'b0, 1);
    drain();
    send(5'b10111, 2'b01, 5'b00101, 1'b1, 1'b0, 2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("busy_in_op", busy, 1'b1);
    end
    @(negedge clk);
    chk("busy_after_op", busy, 1'b0);
    chk("in_ready_after_op", bus.in_ready, 1'b1);
    send(5'b10011, 2'b10, 5'b00110, 1'b1, 1'b0, 1);
    send(5'b00011, 2'b10, 5'b00110, 1'b0, 1'b0, 1);
    send(5'b01101, 2'b11, 5'b01101, 1'b0, 1'b1, 0);
    send(5'b00001, 2'b00, 5'b00000, 1'b1, 1'b0, 1);
    send(5'b10000, 2'b01, 5'b00100, 1'b0, 1'b0, 2);
    send(5'b10000, 2'b10, 5'b00000, 1'b1, 1'b0, 1);
    send(5'b11111, 2'b11, 5'b11111, 1'b0, 1'b1, 0);
    drain();

    // Back-pressure: hold the result and refuse a pending operand.
    bus.out_ready = 1'b0;
    send(5'b10111, 2'b00, 5'b01011, 1'b1, 1'b0, 1);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_rise", bus.out_valid, 1'b1);
    held_data = bus.data_out;
    held_lost = bus.lost;
    bus.in_valid = 1'b1;
    bus.data_in = 5'b00011;
    bus.coefficient = 2'b10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", bus.out_valid, 1'b1);
      chk("bp_data_hold", bus.data_out, 5'b01011);
      chk("bp_lost_hold", bus.lost, 1'b1);
      chk("bp_in_ready", bus.in_ready, 1'b0);
      chk("bp_busy", busy, 1'b1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_idle", bus.in_ready, 1'b1);
    accept_push(5'b00110, 1'b0, 1'b0, 1);
    drain();

    // Reset during a two-step operation: nothing may come out.
    present(5'b10111, 2'b01);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk("mid_rst_data_out", bus.data_out, 5'b00000);
    chk("mid_rst_lost", bus.lost, 1'b0);
    chk("mid_rst_in_ready", bus.in_ready, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mid_rst_no_result", bus.out_valid, 1'b0);
    end
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
